aead_stream_packer: RTL and testbench
=====================================

Name: aead_stream_packer

Overview:
- Upstream feeder for chacha20_poly1305_core.
- Accepts one message as a narrow byte-keep word stream: an AAD segment, then a payload segment.
- Packs the stream into 128-bit blocks with byte keeps and drives the core's aad_*, pld_* and len_* handshakes.
- After the payload, builds and emits the RFC 8439 length block from internal byte counters and signals completion.

Parameters:
- IN_W, 32, input word width in bits; legal values 32, 64, 128; words per block WPB = 128/IN_W.
- CNT_W, 64, byte-counter width; zero-extended into the 64-bit length fields; CNT_W ≤ 64.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a message; ignored unless state IDLE.
- aad_empty  in  1  sampled with start; 1 = message has no AAD segment.
- pld_empty  in  1  sampled with start; 1 = message has no payload segment.
- in_valid  in  1  input word valid.
- in_data  in  IN_W  input word; byte i in bits [8i+7:8i], first byte in lowest lane.
- in_keep  in  IN_W/8  byte enables; must be contiguous from bit 0.
- in_last  in  1  last word of the current segment (AAD or payload).
- in_ready  out  1  word accepted when in_valid && in_ready.
- aad_valid  out  1  AAD block valid.
- aad_data  out  128  AAD block; word k in bits [IN_W*k+IN_W-1 : IN_W*k].
- aad_keep  out  16  AAD byte keep, bit i = byte i.
- aad_ready  in  1  core accepts the AAD block.
- pld_valid, pld_data, pld_keep  out  1/128/16  payload block; same layout as AAD.
- pld_ready  in  1  core accepts the payload block.
- len_valid  out  1  length block valid.
- len_block  out  128  bits [63:0] = AAD byte count, [127:64] = payload byte count.
- len_ready  in  1  core accepts the length block.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on the len handshake.
- proto_err  out  1  sticky; cleared by rst or an accepted start.

Behaviour:
- Reset: all outputs 0, except aad_keep/pld_keep = 0; counters 0; state IDLE; partial block cleared. Reset mid-message aborts with no done.
- States: IDLE -> AAD (start && !aad_empty); IDLE -> PLD (start && aad_empty && !pld_empty); IDLE -> LEN (both empty).
- AAD -> PLD or LEN on acceptance of the AAD block holding in_last (LEN if pld_empty).
- PLD -> LEN on acceptance of the payload block holding in_last.
- LEN -> IDLE on len handshake; done asserts in that same cycle.
- Packing: word index widx (0..WPB-1); an accepted word writes lane widx and sets keep bits for its bytes; lanes not yet written keep data 0, keep 0.
- A block closes when widx == WPB-1 or in_last is set. The closed block moves to the output register; *_valid asserts the next cycle (latency 1 from the closing word).
- Output register holds steady until ready (AXI rule: valid never drops without a handshake).
- in_ready = (state is AAD or PLD) && !(output valid && !ready && widx == WPB-1-equivalent closing word pending). Mid-block words are accepted while the previous block drains.
- No input is accepted after in_last until the phase changes. in_ready = 0 in IDLE and LEN.
- Byte counters add popcount(in_keep) per accepted word to the active segment counter; they wrap modulo 2^CNT_W.
- len_valid asserts the cycle after entering LEN, with counters frozen.
- proto_err set by, with the word still consumed and counted:
  - non-contiguous in_keep;
  - in_keep == 0;
  - in_keep not all-ones without in_last.
- start while busy: ignored, no error.
- Simultaneous handshake and a new closing word: output register reloads in the same cycle, no bubble.

Decomposition:
- Package aead_pkg: state enum (IDLE, AAD, PLD, LEN); BLK_W = 128; KEEP_W = 16; LEN_FIELD_W = 64; function keep_popcount; function keep_is_contiguous.
- Sub-module block_packer (widx, lane write, keep accumulation, output register, valid/ready). The top holds the FSM, counters, length-block build and routing to aad_*/pld_*.

Test Plan:
- IN_W = 32, 4 AAD words 0x03020100..0x0F0E0D0C, last on word 4, keep F; then 4 payload words; ready tied 1 -> one aad block, aad_data = 0x0F0E..0100, keep FFFF; one pld block; len_block = {64'd16, 64'd16}; done one cycle.
- AAD of 5 bytes (words keep F, then keep 1 with last), payload 17 bytes -> aad_keep = 001F; pld blocks keep FFFF then 0001; len_block = {64'd17, 64'd5}.
- aad_empty = pld_empty = 1 -> no aad/pld valid; len_block = 0; done at the len handshake; in_ready stays 0.
- Hold pld_ready = 0 for 10 cycles during a 3-block payload -> pld_data stable; in_ready low only at the closing word; no words lost; length correct.
- Mid-block in_keep = 4'b0101 -> proto_err = 1 and stays 1 until the next accepted start.
- Assert rst during PLD -> next cycle all valids 0, busy 0; a new message completes with counts unaffected by the aborted one.

Source files
------------

// File: rtl/aead_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aead_pkg
// Brief    : Shared types, widths and keep helpers for the AEAD stream packer.
// Revision : 1.0
// ============================================================================
package aead_pkg;

    localparam int BLK_W       = 128;
    localparam int KEEP_W      = 16;
    localparam int LEN_FIELD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AAD  = 2'd1,
        PLD  = 2'd2,
        LEN  = 2'd3
    } state_e;

    function automatic logic [4:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {4'd0, keep[i]};
        end
        return n;
    endfunction

    // Contiguous from bit 0 means keep is of the form 0..01..1.
    function automatic logic keep_is_contiguous(input logic [KEEP_W-1:0] keep);
        return (keep & (keep + KEEP_W'(1))) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_packer.sv
`default_nettype none
// ============================================================================
// Module   : block_packer
// Brief    : Gathers narrow words into a 128-bit block and holds it in a
//            valid/ready output register.
// Revision : 1.0
// ============================================================================
module block_packer
    import aead_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_fire,
    input  logic [IN_W-1:0]     in_data,
    input  logic [IN_W/8-1:0]   in_keep,
    input  logic                in_last,
    output logic                accept_ok,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [BLK_W-1:0]    out_data,
    output logic [KEEP_W-1:0]   out_keep,
    output logic                out_last
);

    localparam int WPB    = BLK_W / IN_W;
    localparam int KW     = IN_W / 8;
    localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WPB - 1);

    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [BLK_W-1:0]  acc_data_q, acc_data_d;
    logic [KEEP_W-1:0] acc_keep_q, acc_keep_d;
    logic              out_valid_q, out_valid_d;
    logic [BLK_W-1:0]  out_data_q, out_data_d;
    logic [KEEP_W-1:0] out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;

    logic              closing_pos;
    logic [BLK_W-1:0]  wr_data;
    logic [KEEP_W-1:0] wr_keep;

    // A closing word may only enter when the output register is free or draining now.
    assign closing_pos = (widx_q == LAST_IDX) || in_last;
    assign accept_ok   = !(out_valid_q && !out_ready && closing_pos);

    always_comb begin
        wr_data     = acc_data_q;
        wr_keep     = acc_keep_q;
        widx_d      = widx_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        for (int k = 0; k < WPB; k++) begin
            if (widx_q == WIDX_W'(k)) begin
                wr_data[k*IN_W +: IN_W] = in_data;
                wr_keep[k*KW +: KW]     = in_keep;
            end
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (closing_pos) begin
                out_valid_d = 1'b1;
                out_data_d  = wr_data;
                out_keep_d  = wr_keep;
                out_last_d  = in_last;
                acc_data_d  = '0;
                acc_keep_d  = '0;
                widx_d      = '0;
            end else begin
                acc_data_d  = wr_data;
                acc_keep_d  = wr_keep;
                widx_d      = widx_q + WIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q      <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            widx_q      <= widx_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: rtl/aead_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : aead_stream_packer
// Brief    : Packs an AAD + payload word stream into 128-bit blocks for the
//            ChaCha20-Poly1305 core and emits the trailing length block.
// Revision : 1.0
// ============================================================================
module aead_stream_packer
    import aead_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int CNT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                aad_empty,
    input  logic                pld_empty,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_data,
    input  logic [IN_W/8-1:0]   in_keep,
    input  logic                in_last,
    output logic                in_ready,
    output logic                aad_valid,
    output logic [BLK_W-1:0]    aad_data,
    output logic [KEEP_W-1:0]   aad_keep,
    input  logic                aad_ready,
    output logic                pld_valid,
    output logic [BLK_W-1:0]    pld_data,
    output logic [KEEP_W-1:0]   pld_keep,
    input  logic                pld_ready,
    output logic                len_valid,
    output logic [BLK_W-1:0]    len_block,
    input  logic                len_ready,
    output logic                busy,
    output logic                done,
    output logic                proto_err
);

    state_e            state_q, state_d;
    logic              pld_empty_q, pld_empty_d;
    logic              seg_done_q, seg_done_d;
    logic              proto_err_q, proto_err_d;
    logic [CNT_W-1:0]  aad_cnt_q, aad_cnt_d;
    logic [CNT_W-1:0]  pld_cnt_q, pld_cnt_d;

    logic              in_fire;
    logic              blk_accept_ok;
    logic              blk_ready;
    logic              blk_valid;
    logic              blk_last;
    logic [BLK_W-1:0]  blk_data;
    logic [KEEP_W-1:0] blk_keep;
    logic              blk_hs;
    logic [KEEP_W-1:0] keep_ext;
    logic              keep_bad;

    assign keep_ext  = KEEP_W'(in_keep);
    assign keep_bad  = !keep_is_contiguous(keep_ext) || (keep_ext == '0) ||
                       (!in_last && !(&in_keep));

    // seg_done blocks further input once the segment's last word is in.
    assign in_ready  = ((state_q == AAD) || (state_q == PLD)) && !seg_done_q && blk_accept_ok;
    assign in_fire   = in_valid && in_ready;
    assign blk_ready = (state_q == AAD) ? aad_ready :
                       (state_q == PLD) ? pld_ready : 1'b0;
    assign blk_hs    = blk_valid && blk_ready;

    block_packer #(
        .IN_W (IN_W)
    ) u_block_packer (
        .clk       (clk),
        .rst       (rst),
        .in_fire   (in_fire),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .accept_ok (blk_accept_ok),
        .out_ready (blk_ready),
        .out_valid (blk_valid),
        .out_data  (blk_data),
        .out_keep  (blk_keep),
        .out_last  (blk_last)
    );

    always_comb begin
        state_d     = state_q;
        pld_empty_d = pld_empty_q;
        seg_done_d  = seg_done_q;
        proto_err_d = proto_err_q;
        aad_cnt_d   = aad_cnt_q;
        pld_cnt_d   = pld_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pld_empty_d = pld_empty;
                    seg_done_d  = 1'b0;
                    proto_err_d = 1'b0;
                    aad_cnt_d   = '0;
                    pld_cnt_d   = '0;
                    state_d     = !aad_empty ? AAD : (!pld_empty ? PLD : LEN);
                end
            end
            AAD: begin
                if (blk_hs && blk_last) begin
                    seg_done_d = 1'b0;
                    state_d    = pld_empty_q ? LEN : PLD;
                end
            end
            PLD: begin
                if (blk_hs && blk_last) begin
                    seg_done_d = 1'b0;
                    state_d    = LEN;
                end
            end
            LEN: begin
                if (len_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_fire) begin
            if (in_last) begin
                seg_done_d = 1'b1;
            end
            if (keep_bad) begin
                proto_err_d = 1'b1;
            end
            if (state_q == AAD) begin
                aad_cnt_d = aad_cnt_q + CNT_W'(keep_popcount(keep_ext));
            end else begin
                pld_cnt_d = pld_cnt_q + CNT_W'(keep_popcount(keep_ext));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pld_empty_q <= 1'b0;
            seg_done_q  <= 1'b0;
            proto_err_q <= 1'b0;
            aad_cnt_q   <= '0;
            pld_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pld_empty_q <= pld_empty_d;
            seg_done_q  <= seg_done_d;
            proto_err_q <= proto_err_d;
            aad_cnt_q   <= aad_cnt_d;
            pld_cnt_q   <= pld_cnt_d;
        end
    end

    assign aad_valid = (state_q == AAD) && blk_valid;
    assign aad_data  = (state_q == AAD) ? blk_data : '0;
    assign aad_keep  = (state_q == AAD) ? blk_keep : '0;
    assign pld_valid = (state_q == PLD) && blk_valid;
    assign pld_data  = (state_q == PLD) ? blk_data : '0;
    assign pld_keep  = (state_q == PLD) ? blk_keep : '0;
    assign len_valid = (state_q == LEN);
    assign len_block = {LEN_FIELD_W'(pld_cnt_q), LEN_FIELD_W'(aad_cnt_q)};
    assign busy      = (state_q != IDLE);
    assign done      = len_valid && len_ready;
    assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_aead_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aead_stream_packer
// Brief    : Directed and randomized bench for aead_stream_packer (IN_W = 32).
// Revision : 1.0
// ============================================================================
module tb_aead_stream_packer;

    localparam int IN_W = 32;
    localparam int KW   = IN_W / 8;

    logic          clk = 1'b0;
    logic          rst, start, aad_empty, pld_empty;
    logic          in_valid, in_last, in_ready;
    logic [IN_W-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic          aad_valid, pld_valid, len_valid, busy, done, proto_err;
    logic [127:0]  aad_data, pld_data, len_block;
    logic [15:0]   aad_keep, pld_keep;
    logic          aad_ready = 1'b1;
    logic          pld_ready = 1'b1;
    logic          len_ready = 1'b1;

    always #5 clk = ~clk;

    aead_stream_packer #(.IN_W(IN_W), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .aad_empty(aad_empty), .pld_empty(pld_empty),
        .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_ready(in_ready),
        .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
        .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
        .busy(busy), .done(done), .proto_err(proto_err)
    );

    int tests = 0;
    int fails = 0;

    // Ready generation: mode 0 = always ready, mode 1 = random; optional 10-cycle pld stall.
    int  ready_mode = 0;
    bit  hold_arm   = 1'b0;
    bit  hold_fired = 1'b0;
    int  hold_left  = 0;

    always @(posedge clk) begin
        #1;
        if (!hold_arm) hold_fired = 1'b0;
        else if (!hold_fired && pld_valid) begin
            hold_fired = 1'b1;
            hold_left  = 10;
        end
        if (ready_mode == 1) begin
            aad_ready = 1'($urandom_range(0, 1));
            pld_ready = 1'($urandom_range(0, 1));
            len_ready = 1'($urandom_range(0, 1));
        end else begin
            aad_ready = 1'b1;
            pld_ready = 1'b1;
            len_ready = 1'b1;
        end
        if (hold_left > 0) begin
            pld_ready = 1'b0;
            hold_left--;
        end
    end

    // Output monitor: records every handshake and watches pld stability under back-pressure.
    logic [127:0] aad_dq[$], pld_dq[$], len_q[$];
    logic [15:0]  aad_kq[$], pld_kq[$];
    int           done_cnt = 0, inrdy_cnt = 0, stab_err = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic [15:0]  prev_keep = '0;

    always @(negedge clk) begin
        if (aad_valid && aad_ready) begin aad_dq.push_back(aad_data); aad_kq.push_back(aad_keep); end
        if (pld_valid && pld_ready) begin pld_dq.push_back(pld_data); pld_kq.push_back(pld_keep); end
        if (len_valid && len_ready) len_q.push_back(len_block);
        if (done) done_cnt++;
        if (in_ready) inrdy_cnt++;
        if (prev_stall && (!pld_valid || pld_data !== prev_data || pld_keep !== prev_keep)) stab_err++;
        prev_stall = pld_valid && !pld_ready && !rst;
        prev_data  = pld_data;
        prev_keep  = pld_keep;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference block i of a byte string: 16-byte chunk, first byte lowest, zero padded.
    function automatic logic [143:0] exp_blk(input logic [7:0] b[$], input int i);
        logic [127:0] d;
        logic [15:0]  k;
        d = '0;
        k = '0;
        for (int j = 0; j < 16; j++) begin
            if (16 * i + j < b.size()) begin
                d[8*j +: 8] = b[16*i + j];
                k[j] = 1'b1;
            end
        end
        return {k, d};
    endfunction

    task automatic start_msg(input logic ae, input logic pe);
        start = 1'b1; aad_empty = ae; pld_empty = pe;
        @(posedge clk); #1;
        start = 1'b0; aad_empty = 1'b0; pld_empty = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic last, input bit gaps);
        bit acc;
        int budget;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = last;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("word_accepted", 128'(acc), 128'd1);
    endtask

    task automatic send_seg(input logic [7:0] b[$], input bit gaps);
        for (int w = 0; w * KW < b.size(); w++) begin
            logic [31:0] d;
            logic [3:0]  k;
            d = '0;
            k = '0;
            for (int j = 0; j < KW; j++) begin
                if (w * KW + j < b.size()) begin
                    d[8*j +: 8] = b[w*KW + j];
                    k[j] = 1'b1;
                end
            end
            send_word(d, k, (w + 1) * KW >= b.size(), gaps);
        end
    endtask

    task automatic wait_done(input int dc);
        int budget = 0;
        while (done_cnt == dc && budget < 500) begin @(posedge clk); #1; budget++; end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Full message against the reference model; ai/pi/li mark where this message's blocks start.
    task automatic run_msg(input logic [7:0] a[$], input logic [7:0] p[$], input bit gaps);
        int ai = aad_dq.size();
        int pi = pld_dq.size();
        int li = len_q.size();
        int dc = done_cnt;
        int na = a.size();
        int np = p.size();
        start_msg(na == 0, np == 0);
        if (na > 0) send_seg(a, gaps);
        if (np > 0) send_seg(p, gaps);
        wait_done(dc);
        check("aad_block_count", 128'(aad_dq.size() - ai), 128'((na + 15) / 16));
        for (int i = 0; i < (na + 15) / 16; i++) begin
            if (ai + i < aad_dq.size()) begin
                check("aad_data", aad_dq[ai+i], 128'(exp_blk(a, i)));
                check("aad_keep", 128'(aad_kq[ai+i]), 128'(exp_blk(a, i) >> 128));
            end
        end
        check("pld_block_count", 128'(pld_dq.size() - pi), 128'((np + 15) / 16));
        for (int i = 0; i < (np + 15) / 16; i++) begin
            if (pi + i < pld_dq.size()) begin
                check("pld_data", pld_dq[pi+i], 128'(exp_blk(p, i)));
                check("pld_keep", 128'(pld_kq[pi+i]), 128'(exp_blk(p, i) >> 128));
            end
        end
        check("len_count", 128'(len_q.size() - li), 128'd1);
        if (len_q.size() > li) check("len_block", len_q[li], {64'(np), 64'(na)});
        check("done_cycles", 128'(done_cnt - dc), 128'd1);
        check("busy_after", 128'(busy), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a[$];
        logic [7:0] p[$];
        int dc, ir, ai, li;

        rst = 1'b1; start = 1'b0; aad_empty = 1'b0; pld_empty = 1'b0;
        in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_outputs", {aad_valid, pld_valid, len_valid, busy, done, proto_err, in_ready}, 128'd0);
        check("rst_keeps", {aad_keep, pld_keep}, 128'd0);
        check("rst_len_block", len_block, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 16-byte AAD 0x00..0x0F and 16-byte payload
        a = {};
        p = {};
        for (int i = 0; i < 16; i++) begin a.push_back(8'(i)); p.push_back(8'(8'h80 + i)); end
        ai = aad_dq.size();
        run_msg(a, p, 1'b0);
        if (aad_dq.size() > ai) check("aad_const", aad_dq[ai], 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // 5-byte AAD, 17-byte payload
        a = {}; p = {};
        for (int i = 0; i < 5; i++) a.push_back(8'($urandom));
        for (int i = 0; i < 17; i++) p.push_back(8'($urandom));
        ai = aad_dq.size();
        run_msg(a, p, 1'b0);
        if (aad_dq.size() > ai) check("aad_keep_001f", 128'(aad_kq[ai]), 128'h001F);

        // Both segments empty: in_ready must never rise
        a = {}; p = {};
        ir = inrdy_cnt;
        run_msg(a, p, 1'b0);
        check("empty_in_ready", 128'(inrdy_cnt - ir), 128'd0);

        // 40-byte payload with a 10-cycle pld stall
        a = {}; p = {};
        for (int i = 0; i < 40; i++) p.push_back(8'($urandom));
        hold_arm = 1'b1;
        run_msg(a, p, 1'b0);
        hold_arm = 1'b0;
        check("pld_stable_under_stall", 128'(stab_err), 128'd0);

        // Protocol error: non-contiguous keep mid-block, then a good last word
        dc = done_cnt; ai = aad_dq.size(); li = len_q.size();
        start_msg(1'b0, 1'b1);
        send_word(32'h00CC00AA, 4'b0101, 1'b0, 1'b0);
        send_word(32'h44332211, 4'b1111, 1'b1, 1'b0);
        wait_done(dc);
        check("proto_err_set", 128'(proto_err), 128'd1);
        if (aad_dq.size() > ai) begin
            check("err_aad_data", aad_dq[ai], 128'h44332211_00CC00AA);
            check("err_aad_keep", 128'(aad_kq[ai]), 128'h00F5);
        end
        if (len_q.size() > li) check("err_len_block", len_q[li], {64'd0, 64'd6});
        repeat (3) begin @(posedge clk); #1; end
        check("proto_err_sticky", 128'(proto_err), 128'd1);
        start_msg(1'b1, 1'b1);
        check("proto_err_cleared", 128'(proto_err), 128'd0);
        wait_done(done_cnt);

        // Zero keep is also an error
        dc = done_cnt;
        start_msg(1'b1, 1'b0);
        send_word(32'h0, 4'b0000, 1'b0, 1'b0);
        send_word(32'h000000AB, 4'b0001, 1'b1, 1'b0);
        wait_done(dc);
        check("proto_err_keep0", 128'(proto_err), 128'd1);

        // Reset mid-payload, then a clean message
        dc = done_cnt;
        start_msg(1'b0, 1'b0);
        send_word(32'h03020100, 4'hF, 1'b1, 1'b0);
        send_word(32'h13121110, 4'hF, 1'b0, 1'b0);
        send_word(32'h17161514, 4'hF, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", {aad_valid, pld_valid, len_valid, busy, in_ready, proto_err}, 128'd0);
        check("abort_no_done", 128'(done_cnt - dc), 128'd0);
        a = {}; p = {};
        for (int i = 0; i < 7; i++) a.push_back(8'($urandom));
        for (int i = 0; i < 9; i++) p.push_back(8'($urandom));
        run_msg(a, p, 1'b0);

        // Randomized lengths, gaps and back-pressure
        ready_mode = 1;
        for (int m = 0; m < 6; m++) begin
            int na, np;
            na = $urandom_range(0, 40);
            np = $urandom_range(0, 60);
            a = {}; p = {};
            for (int i = 0; i < na; i++) a.push_back(8'($urandom));
            for (int i = 0; i < np; i++) p.push_back(8'($urandom));
            run_msg(a, p, 1'b1);
            check("rand_no_proto_err", 128'(proto_err), 128'd0);
        end
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
